// File: rtl/fnd_pkg.sv
// -----------------------------------------------------------------------------
// fnd_pkg
// Shared definitions for the multiplexed 7-segment (FND) driver:
//   - FONT_0..FONT_9 : segment patterns, bits [7:1] = a..g, bit 0 = dp, 1 = lit
//   - SEG_OFF        : all segments dark
//   - seg_font()     : nibble -> font byte (non-decimal nibbles are dark)
//   - bcd_add3()     : the shift-and-add-3 nibble correction
//   - pow10()        : constant helper for the elaboration range check
// -----------------------------------------------------------------------------
package fnd_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [7:0] FONT_0  = 8'hFC;
  localparam logic [7:0] FONT_1  = 8'h60;
  localparam logic [7:0] FONT_2  = 8'hDA;
  localparam logic [7:0] FONT_3  = 8'hF2;
  localparam logic [7:0] FONT_4  = 8'h66;
  localparam logic [7:0] FONT_5  = 8'hB6;
  localparam logic [7:0] FONT_6  = 8'hBE;
  localparam logic [7:0] FONT_7  = 8'hE0;
  localparam logic [7:0] FONT_8  = 8'hFE;
  localparam logic [7:0] FONT_9  = 8'hE6;
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Font lookup; codes 10..15 never come out of the converter and stay dark.
  function automatic logic [7:0] seg_font(input nibble_t nibble);
    logic [7:0] f;
    case (nibble)
      4'd0:    f = FONT_0;
      4'd1:    f = FONT_1;
      4'd2:    f = FONT_2;
      4'd3:    f = FONT_3;
      4'd4:    f = FONT_4;
      4'd5:    f = FONT_5;
      4'd6:    f = FONT_6;
      4'd7:    f = FONT_7;
      4'd8:    f = FONT_8;
      4'd9:    f = FONT_9;
      default: f = SEG_OFF;
    endcase
    return f;
  endfunction

  // Nibbles >= 5 would carry into the next decade after the doubling shift,
  // so they are pre-corrected by +3. Input is at most 9, result at most 12.
  function automatic nibble_t bcd_add3(input nibble_t nibble);
    nibble_t r;
    if (nibble >= 4'd5) begin
      r = nibble + 4'd3;
    end else begin
      r = nibble;
    end
    return r;
  endfunction

  // 10^n as a 64-bit constant, used only at elaboration.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int k = 0; k < n; k++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A value accepted on edge k is converted on edges k+1..k+BIN_W; the last
// iteration also commits the result, so a new value can be accepted in the
// done cycle and conversions run back-to-back every BIN_W+1 cycles.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_p    in   asynchronous active-high reset (aborts a conversion)
//   bin_value  in   [BIN_W-1:0] binary value, sampled on acceptance
//   valid      in   load strobe, honoured only while busy=0
//   busy       out  conversion in progress
//   done       out  one-cycle pulse on the commit edge
//   bcd_out    out  [DIGITS*4-1:0] committed BCD result, digit 0 in [3:0]
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
  import fnd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 12
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic [BIN_W-1:0]      bin_value,
  input  logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd_out
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam longint unsigned BIN_MAX = (64'd1 << BIN_W) - 64'd1;

  if (BIN_W < 2) begin : g_bad_bin_w
    $error("bin_to_bcd_seq: BIN_W must be at least 2");
  end
  if (BIN_MAX > pow10(DIGITS) - 64'd1) begin : g_bad_range
    $error("bin_to_bcd_seq: 2^BIN_W-1 does not fit in DIGITS decimal digits");
  end

  logic [BIN_W-1:0]       shift_r;
  logic [BCD_W-1:0]       work_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   busy_r;
  logic                   done_r;
  logic [BCD_W-1:0]       bcd_r;

  logic [BCD_W-1:0]       adj_s;
  logic [BCD_W+BIN_W-1:0] shifted_s;
  logic [BCD_W-1:0]       work_next_s;
  logic [BIN_W-1:0]       shift_next_s;

  // One iteration: correct every pre-shift nibble, then shift {bcd, bin} left.
  always_comb begin
    adj_s = work_r;
    for (int i = 0; i < DIGITS; i++) begin
      adj_s[4*i +: 4] = bcd_add3(work_r[4*i +: 4]);
    end
    shifted_s = {adj_s, shift_r} << 1;
  end

  assign work_next_s  = shifted_s[BCD_W+BIN_W-1:BIN_W];
  assign shift_next_s = shifted_s[BIN_W-1:0];

  // Acceptance, iteration counting and commit of the finished result.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      shift_r <= '0;
      work_r  <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd_r   <= '0;
    end else begin
      done_r <= 1'b0;
      if (busy_r) begin
        work_r  <= work_next_s;
        shift_r <= shift_next_s;
        if (cnt_r == CNT_LAST) begin
          // Last iteration: commit the freshly shifted value on this edge.
          cnt_r  <= '0;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          bcd_r  <= work_next_s;
        end else begin
          cnt_r <= cnt_r + 1'b1;
        end
      end else if (valid) begin
        shift_r <= bin_value;
        work_r  <= '0;
        cnt_r   <= '0;
        busy_r  <= 1'b1;
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign bcd_out = bcd_r;

endmodule

// File: rtl/fnd_scan_driver.sv
// -----------------------------------------------------------------------------
// fnd_scan_driver
// Multiplexed 7-segment display driver. A binary value is converted to BCD by
// bin_to_bcd_seq; the committed BCD register is then scanned one digit per
// SCAN_DIV clocks onto a shared segment bus with one-hot digit enables.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_p    in   asynchronous active-high reset
//   bin_value  in   [BIN_W-1:0] value to display
//   valid      in   load strobe, honoured only while busy=0
//   dp         in   [DIGITS-1:0] decimal point per digit, bit 0 = rightmost
//   blank_lz   in   leading-zero blanking enable
//   busy       out  conversion in progress
//   done       out  one-cycle pulse when a new result is committed
//   bcd_out    out  [DIGITS*4-1:0] committed BCD value, digit 0 in [3:0]
//   seg_7      out  [7:0] segments a..g in [7:1], dp in [0], output polarity
//   com        out  [DIGITS-1:0] digit enables, one-hot at output polarity
// -----------------------------------------------------------------------------
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int BIN_W          = 12,
  parameter int SCAN_DIV       = 100000,
  parameter int COM_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic [BIN_W-1:0]      bin_value,
  input  logic                  valid,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic [7:0]            seg_7,
  output logic [DIGITS-1:0]     com
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] COM_IDLE = (COM_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("fnd_scan_driver: SCAN_DIV must be at least 2");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("fnd_scan_driver: DIGITS must be at least 1");
  end

  logic [PRE_W-1:0]  presc_r;
  logic [IDX_W-1:0]  idx_r;     // digit that will be driven at the next wrap
  logic [7:0]        seg_r;
  logic [DIGITS-1:0] com_r;

  logic [DIGITS-1:0] blank_s;
  logic              zero_run_s;
  logic [3:0]        nib_s;
  logic              dp_bit_s;
  logic              blank_bit_s;
  logic [DIGITS-1:0] onehot_s;
  logic [7:0]        font_s;
  logic [7:0]        lit_s;

  bin_to_bcd_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_conv (
    .clk       (clk),
    .reset_p   (reset_p),
    .bin_value (bin_value),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out)
  );

  // Leading-zero mask: walk down from the top digit while every digit seen is 0.
  // Digit 0 is never part of the mask.
  always_comb begin
    blank_s    = '0;
    zero_run_s = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s & (bcd_out[4*i +: 4] == 4'd0);
      blank_s[i] = blank_lz & zero_run_s;
    end
  end

  // Select the indexed digit and build its active-high segment byte.
  always_comb begin
    nib_s       = 4'd0;
    dp_bit_s    = 1'b0;
    blank_bit_s = 1'b0;
    onehot_s    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        nib_s       = bcd_out[4*i +: 4];
        dp_bit_s    = dp[i];
        blank_bit_s = blank_s[i];
        onehot_s[i] = 1'b1;
      end else begin
        onehot_s[i] = 1'b0;
      end
    end
    // A blanked digit is dark but keeps its decimal point.
    if (blank_bit_s) begin
      font_s = SEG_OFF;
    end else begin
      font_s = seg_font(nib_s);
    end
    lit_s = {font_s[7:1], dp_bit_s};
  end

  // Prescaler, digit index and output registers; seg_7 and com move together
  // on the wrap edge so the bus never shows a mixed or empty slot.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      presc_r <= '0;
      idx_r   <= '0;
      seg_r   <= SEG_IDLE;
      com_r   <= COM_IDLE;
    end else if (presc_r == PRE_LAST) begin
      presc_r <= '0;
      if (idx_r == IDX_LAST) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + 1'b1;
      end
      seg_r <= (SEG_ACTIVE_LOW != 0) ? ~lit_s : lit_s;
      com_r <= (COM_ACTIVE_LOW != 0) ? ~onehot_s : onehot_s;
    end else begin
      presc_r <= presc_r + 1'b1;
    end
  end

  assign seg_7 = seg_r;
  assign com   = com_r;

endmodule

// File: tb/tb_fnd_scan_driver.sv
module tb_fnd_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 4 digits, 12-bit input, fast scan, active-low com
  logic        reset_a;
  logic [11:0] bin_a;
  logic        valid_a;
  logic [3:0]  dp_a;
  logic        blank_a;
  logic        busy_a, done_a;
  logic [15:0] bcd_a;
  logic [7:0]  seg_a;
  logic [3:0]  com_a;

  fnd_scan_driver #(.DIGITS(4), .BIN_W(12), .SCAN_DIV(4), .COM_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)) dut_a (
    .clk(clk), .reset_p(reset_a), .bin_value(bin_a), .valid(valid_a), .dp(dp_a), .blank_lz(blank_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .seg_7(seg_a), .com(com_a));

  // Instance B: 6 digits, 19-bit input, active-high com, inverted segments
  logic        reset_b;
  logic [18:0] bin_b;
  logic        valid_b;
  logic [5:0]  dp_b;
  logic        blank_b;
  logic        busy_b, done_b;
  logic [23:0] bcd_b;
  logic [7:0]  seg_b;
  logic [5:0]  com_b;

  fnd_scan_driver #(.DIGITS(6), .BIN_W(19), .SCAN_DIV(3), .COM_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset_p(reset_b), .bin_value(bin_b), .valid(valid_b), .dp(dp_b), .blank_lz(blank_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .seg_7(seg_b), .com(com_b));

  int errors = 0;
  int checks = 0;
  logic [7:0] font_tab [10];

  typedef struct {
    int          value;
    logic [3:0]  dp;
    logic        blz;
    logic [15:0] bcd;
    logic [31:0] segs;   // digit i expected in [8*i +: 8], active-high
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic longint p10(input int n);
    longint p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic int digit_of(input longint v, input int i);
    return int'((v / p10(i)) % 10);
  endfunction

  function automatic logic [63:0] model_bcd(input longint v, input int nd);
    logic [63:0] r = '0;
    for (int i = 0; i < nd; i++) r = r | (64'(digit_of(v, i)) << (4 * i));
    return r;
  endfunction

  function automatic logic [63:0] model_segs(input longint v, input int nd, input logic [7:0] dpv, input logic blz);
    logic [63:0] r = '0;
    logic [7:0]  s;
    for (int i = 0; i < nd; i++) begin
      if (blz && i > 0 && v < p10(i)) s = 8'h00;
      else s = font_tab[digit_of(v, i)];
      s[0] = dpv[i];
      r[8*i +: 8] = s;
    end
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic load_a(input int v);
    bin_a = 12'(v);
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_a !== 1'b1 && n < 40);
    if (done_a !== 1'b1) check("done_a timeout", {63'd0, done_a}, 64'd1);
  endtask

  task automatic wait_done_b(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_b !== 1'b1 && n < 40);
    if (done_b !== 1'b1) check("done_b timeout", {63'd0, done_b}, 64'd1);
  endtask

  // Observe one full scan round on A and compare each cycle against expectations.
  task automatic scan_a(input logic [31:0] exp_segs, input string tag);
    logic [3:0] oh;
    int idx;
    repeat (20) @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      oh = ~com_a;
      idx = -1;
      for (int i = 0; i < 4; i++) if (oh == (4'b0001 << i)) idx = i;
      if (idx < 0) begin
        checks++; errors++;
        $display("FAIL %s com_a not one-hot: got %b", tag, com_a);
      end else begin
        check(tag, {56'd0, seg_a}, {56'd0, exp_segs[8*idx +: 8]});
      end
      @(negedge clk);
    end
  endtask

  task automatic scan_b(input logic [47:0] exp_segs, input string tag);
    logic [7:0] inv;
    int idx;
    repeat (21) @(negedge clk);
    for (int c = 0; c < 18; c++) begin
      idx = -1;
      for (int i = 0; i < 6; i++) if (com_b == (6'b000001 << i)) idx = i;
      if (idx < 0) begin
        checks++; errors++;
        $display("FAIL %s com_b not one-hot: got %b", tag, com_b);
      end else begin
        inv = ~exp_segs[8*idx +: 8];
        check(tag, {56'd0, seg_b}, {56'd0, inv});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int d;
    int v;
    logic [3:0]  prev;
    logic [7:0]  exp_seg1203 [4];
    logic [3:0]  exp_com1203 [4];
    logic [63:0] segs;

    font_tab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hE6};
    exp_seg1203 = '{8'hF2, 8'hFC, 8'hDB, 8'h60};
    exp_com1203 = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    vecs[0] = '{1203, 4'b0100, 1'b0, 16'h1203, 32'h60DBFCF2};
    vecs[1] = '{7,    4'b0000, 1'b1, 16'h0007, 32'h000000E0};
    vecs[2] = '{0,    4'b0000, 1'b1, 16'h0000, 32'h000000FC};
    vecs[3] = '{1000, 4'b0000, 1'b1, 16'h1000, 32'h60FCFCFC};
    vecs[4] = '{4095, 4'b1111, 1'b1, 16'h4095, 32'h67FDE7B7};
    vecs[5] = '{50,   4'b0010, 1'b1, 16'h0050, 32'h0000B7FC};
    vecs[6] = '{5,    4'b1000, 1'b1, 16'h0005, 32'h010000B6};
    vecs[7] = '{7,    4'b0000, 1'b0, 16'h0007, 32'hFCFCFCE0};

    reset_a = 1'b1; bin_a = '0; valid_a = 1'b0; dp_a = '0; blank_a = 1'b0;
    reset_b = 1'b1; bin_b = '0; valid_b = 1'b0; dp_b = '0; blank_b = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst busy_a", {63'd0, busy_a}, 64'd0);
    check("rst done_a", {63'd0, done_a}, 64'd0);
    check("rst bcd_a",  {48'd0, bcd_a},  64'd0);
    check("rst com_a",  {60'd0, com_a},  64'hF);
    check("rst seg_a",  {56'd0, seg_a},  64'h00);
    check("rst com_b",  {58'd0, com_b},  64'h00);
    check("rst seg_b",  {56'd0, seg_b},  64'hFF);
    check("rst bcd_b",  {40'd0, bcd_b},  64'd0);

    // First digit enable appears on the first prescaler wrap
    reset_a = 1'b0; reset_b = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (com_a === 4'hF && n < 20);
    check("first wrap cycles", 64'(n), 64'd4);
    check("first wrap com_a", {60'd0, com_a}, 64'hE);

    // Reset mid-conversion aborts without a done pulse
    load_a(4095);
    check("abort busy rise", {63'd0, busy_a}, 64'd1);
    repeat (4) @(negedge clk);
    reset_a = 1'b1;
    #1;
    check("abort busy", {63'd0, busy_a}, 64'd0);
    check("abort bcd",  {48'd0, bcd_a},  64'd0);
    check("abort done", {63'd0, done_a}, 64'd0);
    @(negedge clk);
    reset_a = 1'b0;
    d = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_a === 1'b1) d++;
    end
    check("abort no done", 64'(d), 64'd0);

    // Fresh conversion: done 12 cycles after busy rises
    bin_a = 12'd4095; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    check("fresh busy rise", {63'd0, busy_a}, 64'd1);
    wait_done_a(n);
    check("fresh latency", 64'(n), 64'd12);
    check("fresh bcd", {48'd0, bcd_a}, 64'h4095);
    check("fresh busy low", {63'd0, busy_a}, 64'd0);

    // Table-driven display vectors
    for (int k = 0; k < 8; k++) begin
      dp_a = vecs[k].dp;
      blank_a = vecs[k].blz;
      load_a(vecs[k].value);
      wait_done_a(n);
      check($sformatf("vec%0d bcd", k), {48'd0, bcd_a}, {48'd0, vecs[k].bcd});
      scan_a(vecs[k].segs, $sformatf("vec%0d seg", k));
    end

    // Exact scan order and slot length for 1203
    dp_a = 4'b0100; blank_a = 1'b0;
    load_a(1203);
    wait_done_a(n);
    repeat (20) @(negedge clk);
    prev = com_a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (com_a === prev && n < 10);
    d = -1;
    for (int i = 0; i < 4; i++) if (com_a == exp_com1203[i]) d = i;
    if (d < 0) begin
      checks++; errors++;
      $display("FAIL seq start com: got %b", com_a);
    end else begin
      for (int s = 0; s < 8; s++) begin
        for (int c = 0; c < 4; c++) begin
          check("seq com", {60'd0, com_a}, {60'd0, exp_com1203[d]});
          check("seq seg", {56'd0, seg_a}, {56'd0, exp_seg1203[d]});
          @(negedge clk);
        end
        d = (d + 1) % 4;
      end
    end

    // valid during busy is dropped
    load_a(1234);
    repeat (3) @(negedge clk);
    bin_a = 12'd999; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    wait_done_a(n);
    check("drop bcd", {48'd0, bcd_a}, 64'h1234);
    @(negedge clk);
    check("drop no reload", {63'd0, busy_a}, 64'd0);

    // Exhaustive back-to-back with valid held high
    bin_a = 12'd0; valid_a = 1'b1;
    for (int x = 0; x < 4096; x++) begin
      wait_done_a(n);
      check("b2b interval", 64'(n), 64'd13);
      check("b2b bcd", {48'd0, bcd_a}, model_bcd(x, 4));
      if (x == 4095) valid_a = 1'b0;
      else bin_a = 12'(x + 1);
    end
    @(negedge clk);

    // Randomized values against the reference model
    for (int k = 0; k < 40; k++) begin
      v = int'($urandom_range(0, 4095));
      dp_a = 4'($urandom);
      blank_a = 1'($urandom_range(0, 1));
      load_a(v);
      wait_done_a(n);
      check("rnd bcd", {48'd0, bcd_a}, model_bcd(v, 4));
      segs = model_segs(v, 4, {4'd0, dp_a}, blank_a);
      scan_a(segs[31:0], "rnd seg");
    end

    // Wide instance: 6 digits, inverted polarities
    dp_b = 6'b000001; blank_b = 1'b1;
    bin_b = 19'd524287; valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
    wait_done_b(n);
    check("b latency", 64'(n), 64'd19);
    check("b bcd max", {40'd0, bcd_b}, 64'h524287);
    segs = model_segs(524287, 6, {2'd0, dp_b}, blank_b);
    scan_b(segs[47:0], "b seg max");
    for (int k = 0; k < 3; k++) begin
      v = int'($urandom_range(0, 524287));
      dp_b = 6'($urandom);
      bin_b = 19'(v); valid_b = 1'b1;
      @(negedge clk);
      valid_b = 1'b0;
      wait_done_b(n);
      check("b rnd bcd", {40'd0, bcd_b}, model_bcd(v, 6));
      segs = model_segs(v, 6, {2'd0, dp_b}, blank_b);
      scan_b(segs[47:0], "b rnd seg");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
